// File: rtl/img_rect_ctrl_if.sv
// Box request bus from the upstream detector: corners, colour and a valid/ready handshake.
interface img_rect_ctrl_if;
   logic        box_valid;
   logic        box_ready;
   logic [10:0] box_x1;
   logic [10:0] box_y1;
   logic [10:0] box_x2;
   logic [10:0] box_y2;
   logic [23:0] box_color;

   modport master (
      output box_valid, box_x1, box_y1, box_x2, box_y2, box_color,
      input  box_ready
   );

   modport slave (
      input  box_valid, box_x1, box_y1, box_x2, box_y2, box_color,
      output box_ready
   );
endinterface

// File: rtl/img_rect_ctrl.sv
// Box scheduler for the rectangle overlay: queues sanitised boxes and commits one per frame on vs rise.
// Optional feature: define BOX_TIMEOUT_EN to hide a box after HOLD_FRAMES frames without a new one.
module img_rect_ctrl #(
   parameter int unsigned IMG_W       = 640,
   parameter int unsigned IMG_H       = 480,
   parameter int unsigned DEPTH       = 4,
   parameter int unsigned HOLD_FRAMES = 30,
   parameter int unsigned HIDE_COORD  = 2040
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     vs_i,
   input  logic                     clr_i,
   img_rect_ctrl_if.slave           box,
   output logic [10:0]              rect_x1,
   output logic [10:0]              rect_y1,
   output logic [10:0]              rect_x2,
   output logic [10:0]              rect_y2,
   output logic [23:0]              rect_color,
   output logic                     rect_vld,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int unsigned CW   = 11;
   localparam int unsigned COLW = 24;
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned LW   = AW + 1;

   localparam logic [CW-1:0] X_MAX = CW'(IMG_W - 1);
   localparam logic [CW-1:0] Y_MAX = CW'(IMG_H - 1);
   localparam logic [CW-1:0] HIDE  = CW'(HIDE_COORD);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("img_rect_ctrl: DEPTH must be a power of 2 and >= 2");
   end
   if (HOLD_FRAMES < 1) begin : g_bad_hold
      $error("img_rect_ctrl: HOLD_FRAMES must be >= 1");
   end

   typedef struct packed {
      logic [CW-1:0]   x_lo;
      logic [CW-1:0]   y_lo;
      logic [CW-1:0]   x_hi;
      logic [CW-1:0]   y_hi;
      logic [COLW-1:0] color;
   } box_t;

   typedef enum logic {HIDDEN, SHOWN} state_t;

   state_t        state_q, state_d;
   box_t          rect_q, rect_d;
   logic          vld_q, vld_d;
   logic          vs_d_q;
   logic          vs_rise;

   box_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          full, empty;
   logic          push, pop;

   logic [CW-1:0] x_lo, x_hi, y_lo, y_hi;
   box_t          push_entry;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign vs_rise = vs_i & ~vs_d_q;

   // Ready drops combinationally during a flush so nothing lands in a FIFO being cleared.
   assign box.box_ready = ~full & ~clr_i;
   assign push          = box.box_valid & box.box_ready;

   // Order corners so (lo, hi) is top-left/bottom-right, then clamp to the active area.
   always_comb begin : sanitise
      x_lo = (box.box_x1 <= box.box_x2) ? box.box_x1 : box.box_x2;
      x_hi = (box.box_x1 <= box.box_x2) ? box.box_x2 : box.box_x1;
      y_lo = (box.box_y1 <= box.box_y2) ? box.box_y1 : box.box_y2;
      y_hi = (box.box_y1 <= box.box_y2) ? box.box_y2 : box.box_y1;

      push_entry.x_lo  = (x_lo > X_MAX) ? X_MAX : x_lo;
      push_entry.x_hi  = (x_hi > X_MAX) ? X_MAX : x_hi;
      push_entry.y_lo  = (y_lo > Y_MAX) ? Y_MAX : y_lo;
      push_entry.y_hi  = (y_hi > Y_MAX) ? Y_MAX : y_hi;
      push_entry.color = box.box_color;
   end

`ifdef BOX_TIMEOUT_EN
   localparam int unsigned TW = $clog2(HOLD_FRAMES + 1);
   logic [TW-1:0] cnt_q, cnt_d;
`endif

   // Next-state and commit logic; clear wins over any vs-driven pop.
   always_comb begin : fsm_comb
      state_d = state_q;
      rect_d  = rect_q;
      vld_d   = vld_q;
      pop     = 1'b0;
`ifdef BOX_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      if (clr_i) begin
         state_d     = HIDDEN;
         rect_d.x_lo = HIDE;
         rect_d.y_lo = HIDE;
         rect_d.x_hi = HIDE;
         rect_d.y_hi = HIDE;
         vld_d       = 1'b0;
      end else begin
         unique case (state_q)
            HIDDEN: begin
               if (vs_rise && !empty) begin
                  pop     = 1'b1;
                  rect_d  = mem[rd_ptr_q];
                  vld_d   = 1'b1;
                  state_d = SHOWN;
`ifdef BOX_TIMEOUT_EN
                  cnt_d   = '0;
`endif
               end
            end
            SHOWN: begin
               if (vs_rise && !empty) begin
                  pop    = 1'b1;
                  rect_d = mem[rd_ptr_q];
`ifdef BOX_TIMEOUT_EN
                  cnt_d  = '0;
`endif
               end else if (vs_rise) begin
`ifdef BOX_TIMEOUT_EN
                  if (cnt_q == TW'(HOLD_FRAMES - 1)) begin
                     state_d     = HIDDEN;
                     rect_d.x_lo = HIDE;
                     rect_d.y_lo = HIDE;
                     rect_d.x_hi = HIDE;
                     rect_d.y_hi = HIDE;
                     vld_d       = 1'b0;
                  end else if (cnt_q != '1) begin
                     cnt_d = cnt_q + TW'(1);
                  end
`else
                  vld_d = 1'b1;
`endif
               end
            end
            default: state_d = HIDDEN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin : state_reg
      if (!rst_n) begin
         state_q      <= HIDDEN;
         rect_q.x_lo  <= HIDE;
         rect_q.y_lo  <= HIDE;
         rect_q.x_hi  <= HIDE;
         rect_q.y_hi  <= HIDE;
         rect_q.color <= '0;
         vld_q        <= 1'b0;
         vs_d_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         rect_q  <= rect_d;
         vld_q   <= vld_d;
         vs_d_q  <= vs_i;
      end
   end

`ifdef BOX_TIMEOUT_EN
   always_ff @(posedge clk or negedge rst_n) begin : cnt_reg
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin : fifo_ctrl
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else if (clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         unique case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin : fifo_mem
      if (push) mem[wr_ptr_q] <= push_entry;
   end

   assign rect_x1    = rect_q.x_lo;
   assign rect_y1    = rect_q.y_lo;
   assign rect_x2    = rect_q.x_hi;
   assign rect_y2    = rect_q.y_hi;
   assign rect_color = rect_q.color;
   assign rect_vld   = vld_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_img_rect_ctrl.sv
// Directed bench for img_rect_ctrl: vector table for sanitising plus hand sequences for frame-sync corners.
module tb_img_rect_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic vs_i  = 1'b0;
   logic clr_i = 1'b0;

   logic [10:0] rx1, ry1, rx2, ry2;
   logic [23:0] rcol;
   logic        rvld;
   logic [2:0]  lvl;

   always #5 clk = ~clk;

   img_rect_ctrl_if bif ();

   img_rect_ctrl #(.HOLD_FRAMES(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vs_i       (vs_i),
      .clr_i      (clr_i),
      .box        (bif),
      .rect_x1    (rx1),
      .rect_y1    (ry1),
      .rect_x2    (rx2),
      .rect_y2    (ry2),
      .rect_color (rcol),
      .rect_vld   (rvld),
      .fifo_level (lvl)
   );

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int x1, y1, x2, y2, c;
      int ex1, ey1, ex2, ey2;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_box(input int x1, input int y1, input int x2, input int y2, input int c);
      bif.box_x1    = 11'(x1);
      bif.box_y1    = 11'(y1);
      bif.box_x2    = 11'(x2);
      bif.box_y2    = 11'(y2);
      bif.box_color = 24'(c);
   endtask

   task automatic push_box(input int x1, input int y1, input int x2, input int y2, input int c);
      int i;
      set_box(x1, y1, x2, y2, c);
      bif.box_valid = 1'b1;
      i = 0;
      while (!bif.box_ready && i < 50) begin
         tick();
         i++;
      end
      if (!bif.box_ready) chk("push_timeout", int'(bif.box_ready), 1);
      tick();
      bif.box_valid = 1'b0;
   endtask

   task automatic vs_pulse();
      vs_i = 1'b1;
      tick();
      vs_i = 1'b0;
      tick();
   endtask

   task automatic chk_rect(input string name, input int x1, input int y1, input int x2, input int y2,
                           input int vld);
      chk({name, "_x1"}, int'(rx1), x1);
      chk({name, "_y1"}, int'(ry1), y1);
      chk({name, "_x2"}, int'(rx2), x2);
      chk({name, "_y2"}, int'(ry2), y2);
      chk({name, "_vld"}, int'(rvld), vld);
   endtask

   initial begin
      vecs[0] = '{700, 500,  10,  20, 24'hFF0000,  10,  20, 639, 479};
      vecs[1] = '{  5,   6, 100, 200, 24'h00FF00,   5,   6, 100, 200};
      vecs[2] = '{300, 400, 200, 100, 24'h0000FF, 200, 100, 300, 400};
      vecs[3] = '{2047, 2047,  0,   0, 24'h123456,   0,   0, 639, 479};
      vecs[4] = '{639, 479, 639, 479, 24'hABCDEF, 639, 479, 639, 479};
      vecs[5] = '{640, 480, 640, 480, 24'h0F0F0F, 639, 479, 639, 479};

      bif.box_valid = 1'b0;
      set_box(0, 0, 0, 0, 0);

      // Power-on reset
      #2 rst_n = 1'b0;
      #1;
      chk_rect("rst", 2040, 2040, 2040, 2040, 0);
      chk("rst_color", int'(rcol), 0);
      chk("rst_ready", int'(bif.box_ready), 1);
      chk("rst_level", int'(lvl), 0);
      #9 rst_n = 1'b1;
      tick();

      // Sanitise table: swap and clamp, one box per frame
      for (int v = 0; v < 6; v++) begin
         push_box(vecs[v].x1, vecs[v].y1, vecs[v].x2, vecs[v].y2, vecs[v].c);
         chk($sformatf("vec%0d_level_pre", v), int'(lvl), 1);
         vs_pulse();
         chk_rect($sformatf("vec%0d", v), vecs[v].ex1, vecs[v].ey1, vecs[v].ex2, vecs[v].ey2, 1);
         chk($sformatf("vec%0d_color", v), int'(rcol), vecs[v].c);
         chk($sformatf("vec%0d_level", v), int'(lvl), 0);
      end

      // Mid-frame push does not disturb the shown box
      push_box(1, 2, 3, 4, 24'h111111);
      tick(); tick();
      chk_rect("midframe", 639, 479, 639, 479, 1);
      push_box(11, 12, 13, 14, 24'h222222);
      push_box(21, 22, 23, 24, 24'h333333);
      chk("three_level", int'(lvl), 3);

      // Long vs high commits exactly one box
      vs_i = 1'b1;
      tick();
      chk_rect("frameA", 1, 2, 3, 4, 1);
      tick(); tick();
      chk("vs_held_level", int'(lvl), 2);
      chk("vs_held_x1", int'(rx1), 1);
      vs_i = 1'b0;
      tick();
      vs_pulse();
      chk_rect("frameB", 11, 12, 13, 14, 1);
      vs_pulse();
      chk_rect("frameC", 21, 22, 23, 24, 1);
      chk("frameC_level", int'(lvl), 0);

      // Push coinciding with vs rise on an empty FIFO waits a frame
      set_box(31, 32, 33, 34, 24'h444444);
      bif.box_valid = 1'b1;
      vs_i = 1'b1;
      tick();
      bif.box_valid = 1'b0;
      chk("samecyc_x1", int'(rx1), 21);
      chk("samecyc_level", int'(lvl), 1);
      vs_i = 1'b0;
      tick();
      vs_pulse();
      chk_rect("samecyc_next", 31, 32, 33, 34, 1);

      // Full FIFO stalls the fifth request until a frame pops one
      for (int i = 0; i < 4; i++) push_box(i * 10, i * 10, i * 10 + 5, i * 10 + 5, i);
      chk("full_level", int'(lvl), 4);
      set_box(100, 101, 102, 103, 24'h555555);
      bif.box_valid = 1'b1;
      #1;
      chk("full_ready", int'(bif.box_ready), 0);
      tick(); tick();
      chk("full_stall_level", int'(lvl), 4);
      vs_i = 1'b1;
      tick();
      chk("full_pop_x1", int'(rx1), 0);
      chk("full_pop_level", int'(lvl), 3);
      chk("full_pop_ready", int'(bif.box_ready), 1);
      vs_i = 1'b0;
      tick();
      bif.box_valid = 1'b0;
      chk("full_refill_level", int'(lvl), 4);

      // Clear while shown with three entries queued
      vs_pulse();
      chk_rect("pre_clr", 10, 10, 15, 15, 1);
      chk("pre_clr_level", int'(lvl), 3);
      clr_i = 1'b1;
      #1;
      chk("clr_ready", int'(bif.box_ready), 0);
      tick();
      clr_i = 1'b0;
      #1;
      chk_rect("clr", 2040, 2040, 2040, 2040, 0);
      chk("clr_level", int'(lvl), 0);
      chk("clr_ready_after", int'(bif.box_ready), 1);
      vs_pulse();
      chk("clr_vs_vld", int'(rvld), 0);

      // Async reset mid-stream
      push_box(40, 41, 42, 43, 24'h666666);
      push_box(44, 45, 46, 47, 24'h777777);
      vs_pulse();
      chk("prerst_vld", int'(rvld), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_rect("midrst", 2040, 2040, 2040, 2040, 0);
      chk("midrst_ready", int'(bif.box_ready), 1);
      chk("midrst_level", int'(lvl), 0);
      #2 rst_n = 1'b1;
      tick();
      vs_pulse();
      chk("postrst_vld", int'(rvld), 0);

      // Hold behaviour with no new boxes
      push_box(50, 60, 70, 80, 24'h888888);
      vs_pulse();
      chk_rect("hold_start", 50, 60, 70, 80, 1);
`ifdef BOX_TIMEOUT_EN
      vs_pulse();
      vs_pulse();
      chk_rect("hold_2", 50, 60, 70, 80, 1);
      vs_pulse();
      chk_rect("hold_timeout", 2040, 2040, 2040, 2040, 0);
`else
      for (int f = 0; f < 100; f++) vs_pulse();
      chk_rect("hold_100", 50, 60, 70, 80, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
